// File: rtl/gate_window_gen.sv
// gate_window_gen: hit-triggered gate pulse with programmable delay, width and dead time
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   hit_in                 synchronous hit level; a rising edge is a hit
//   dly_cfg/wid_cfg/dead_cfg  delay, width (0 acts as 1) and dead time, latched per hit
//   retrig_en              a hit during the gate restarts the width count
//   gate_out, busy         registered gate and non-idle indication
//   hit_lost               one-cycle pulse for a hit that could not be served
//   acc_cnt, lost_cnt      saturating accepted/lost hit counters
module gate_window_gen #(
    parameter int TW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hit_in,
    input  logic [TW-1:0] dly_cfg,
    input  logic [TW-1:0] wid_cfg,
    input  logic [TW-1:0] dead_cfg,
    input  logic          retrig_en,
    output logic          gate_out,
    output logic          busy,
    output logic          hit_lost,
    output logic [CW-1:0] acc_cnt,
    output logic [CW-1:0] lost_cnt
);
    typedef enum logic [1:0] {IDLE, DELAY, GATE, DEAD} state_t;
    state_t state, nextState;
    // cnt holds remaining cycles in the current state minus one
    logic [TW-1:0] cnt, nextCnt, widLat, nextWidLat, deadLat, nextDeadLat, widEff;
    logic hitQ, hitEdge, accept, lose;
    assign widEff = (wid_cfg == '0) ? TW'(1) : wid_cfg;
    // hitQ resets to 1 so a level already high at reset release is not an edge
    assign hitEdge = hit_in & ~hitQ;
    always_comb begin
        nextState = state;
        nextCnt = cnt;
        nextWidLat = widLat;
        nextDeadLat = deadLat;
        accept = 1'b0;
        lose = 1'b0;
        case (state)
            IDLE: if (hitEdge) begin
                accept = 1'b1;
                nextWidLat = widEff;
                nextDeadLat = dead_cfg;
                nextState = (dly_cfg != '0) ? DELAY : GATE;
                nextCnt = (dly_cfg != '0) ? dly_cfg - TW'(1) : widEff - TW'(1);
            end
            DELAY: begin
                lose = hitEdge;
                nextState = (cnt == '0) ? GATE : DELAY;
                nextCnt = (cnt == '0) ? widLat - TW'(1) : cnt - TW'(1);
            end
            GATE: if (hitEdge && retrig_en) begin
                // retrigger takes priority, including on the final gate cycle
                accept = 1'b1;
                nextCnt = widEff - TW'(1);
            end else begin
                lose = hitEdge;
                nextState = (cnt != '0) ? GATE : (deadLat != '0) ? DEAD : IDLE;
                nextCnt = (cnt == '0) ? deadLat - TW'(1) : cnt - TW'(1);
            end
            DEAD: begin
                lose = hitEdge;
                nextState = (cnt == '0) ? IDLE : DEAD;
                nextCnt = cnt - TW'(1);
            end
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            widLat <= '0;
            deadLat <= '0;
            hitQ <= 1'b1;
            gate_out <= 1'b0;
            busy <= 1'b0;
            hit_lost <= 1'b0;
            acc_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            widLat <= nextWidLat;
            deadLat <= nextDeadLat;
            hitQ <= hit_in;
            gate_out <= (nextState == GATE);
            busy <= (nextState != IDLE);
            hit_lost <= lose;
            acc_cnt <= (accept && ~&acc_cnt) ? acc_cnt + CW'(1) : acc_cnt;
            lost_cnt <= (lose && ~&lost_cnt) ? lost_cnt + CW'(1) : lost_cnt;
        end
    end
endmodule

// File: tb/tb_gate_window_gen.sv
// tb_gate_window_gen: table, directed and random checks of gate_window_gen against an interval model
module tb_gate_window_gen;
    localparam int TW = 8;
    localparam int CW = 16;
    localparam int SW = 3;
    localparam int SMAX = (1 << SW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hitIn = 1'b0;
    logic retrigEn = 1'b0;
    logic [TW-1:0] dlyCfg = '0;
    logic [TW-1:0] widCfg = '0;
    logic [TW-1:0] deadCfg = '0;
    logic gateOut, busy, hitLost, gate2, busy2, hitLost2;
    logic [CW-1:0] accCnt, lostCnt;
    logic [SW-1:0] acc2, lost2;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    // model: absolute-cycle windows of the current transaction
    int mPrev, mTs, mGs, mGe, mBe, mT, mLostAt, mAcc, mLost;
    int n, a0, l0;

    gate_window_gen #(.TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .hit_in(hitIn), .dly_cfg(dlyCfg), .wid_cfg(widCfg),
        .dead_cfg(deadCfg), .retrig_en(retrigEn), .gate_out(gateOut), .busy(busy),
        .hit_lost(hitLost), .acc_cnt(accCnt), .lost_cnt(lostCnt));
    gate_window_gen #(.TW(TW), .CW(SW)) dutSmall (
        .clk(clk), .rst(rst), .hit_in(hitIn), .dly_cfg(dlyCfg), .wid_cfg(widCfg),
        .dead_cfg(deadCfg), .retrig_en(retrigEn), .gate_out(gate2), .busy(busy2),
        .hit_lost(hitLost2), .acc_cnt(acc2), .lost_cnt(lost2));

    always #5 clk = ~clk;

    typedef struct {
        int d; int w; int t; int gFirst; int gLast; int bLast;
    } vec_t;
    vec_t vecs[8];

    function automatic int mx1(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mPrev = 1; mTs = 1; mBe = 0; mGs = 1; mGe = 0; mT = 0;
        mLostAt = -1; mAcc = 0; mLost = 0;
    endtask

    task automatic modelCycle();
        int c;
        bit e;
        c = cyc;
        if (rst) begin
            modelReset();
        end else begin
            e = hitIn && (mPrev == 0);
            mPrev = int'(hitIn);
            if (e) begin
                if (mTs <= c && c <= mBe) begin
                    if (retrigEn && mGs <= c && c <= mGe) begin
                        mGe = c + mx1(int'(widCfg));
                        mBe = mGe + mT;
                        mAcc++;
                    end else begin
                        mLost++;
                        mLostAt = c + 1;
                    end
                end else begin
                    mT = int'(deadCfg);
                    mTs = c + 1;
                    mGs = c + 1 + int'(dlyCfg);
                    mGe = c + int'(dlyCfg) + mx1(int'(widCfg));
                    mBe = mGe + mT;
                    mAcc++;
                end
            end
        end
    endtask

    task automatic step();
        modelCycle();
        @(posedge clk);
        #1;
        cyc++;
        chk("gate_out", int'(gateOut), int'(mGs <= cyc && cyc <= mGe));
        chk("busy", int'(busy), int'(mTs <= cyc && cyc <= mBe));
        chk("hit_lost", int'(hitLost), int'(mLostAt == cyc));
        chk("acc_cnt", int'(accCnt), sat(mAcc, 65535));
        chk("lost_cnt", int'(lostCnt), sat(mLost, 65535));
        chk("small gate_out", int'(gate2), int'(mGs <= cyc && cyc <= mGe));
        chk("small acc_cnt", int'(acc2), sat(mAcc, SMAX));
        chk("small lost_cnt", int'(lost2), sat(mLost, SMAX));
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic edgeHit();
        hitIn = 1'b1;
        step();
        hitIn = 1'b0;
    endtask

    task automatic cfg(input int d, input int w, input int t, input bit r);
        dlyCfg = TW'(d);
        widCfg = TW'(w);
        deadCfg = TW'(t);
        retrigEn = r;
    endtask

    initial begin
        vecs[0] = '{3, 4, 0, 4, 7, 7};
        vecs[1] = '{0, 0, 2, 1, 1, 3};
        vecs[2] = '{0, 1, 0, 1, 1, 1};
        vecs[3] = '{2, 5, 0, 3, 7, 7};
        vecs[4] = '{5, 2, 3, 6, 7, 10};
        vecs[5] = '{0, 3, 4, 1, 3, 7};
        vecs[6] = '{1, 0, 1, 2, 2, 3};
        vecs[7] = '{255, 2, 1, 256, 257, 258};
        modelReset();
        rst = 1'b1;
        run(3);
        chk("reset gate_out", int'(gateOut), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset acc_cnt", int'(accCnt), 0);
        rst = 1'b0;
        run(2);
        // single hits from idle: windows relative to the hit cycle
        for (int i = 0; i < 8; i++) begin
            cfg(vecs[i].d, vecs[i].w, vecs[i].t, 1'b0);
            edgeHit();
            for (int k = 1; k <= vecs[i].bLast + 2; k++) begin
                chk($sformatf("vec%0d gate k=%0d", i, k), int'(gateOut),
                    int'(k >= vecs[i].gFirst && k <= vecs[i].gLast));
                chk($sformatf("vec%0d busy k=%0d", i, k), int'(busy), int'(k <= vecs[i].bLast));
                if (k == 1) cfg(7, 9, 6, 1'b0);
                step();
            end
            chk($sformatf("vec%0d acc_cnt", i), int'(accCnt), i + 1);
        end
        // edge on final dead cycle is lost, next one accepted
        cfg(0, 0, 2, 1'b0);
        edgeHit();
        run(2);
        a0 = int'(accCnt); l0 = int'(lostCnt);
        edgeHit();
        chk("dead last lost pulse", int'(hitLost), 1);
        chk("dead last busy", int'(busy), 0);
        chk("dead last lost_cnt", int'(lostCnt), l0 + 1);
        step();
        edgeHit();
        chk("after dead busy", int'(busy), 1);
        chk("after dead gate", int'(gateOut), 1);
        chk("after dead acc_cnt", int'(accCnt), a0 + 1);
        run(5);
        // edge on the cycle after dead ends is accepted
        edgeHit();
        run(3);
        edgeHit();
        chk("idle edge no lost", int'(hitLost), 0);
        chk("idle edge busy", int'(busy), 1);
        run(5);
        // retrigger extends the gate
        cfg(2, 5, 0, 1'b1);
        a0 = int'(accCnt); l0 = int'(lostCnt); n = cyc;
        edgeHit();
        run(4);
        edgeHit();
        for (int k = 6; k <= 12; k++) begin
            chk($sformatf("retrig gate k=%0d", k), int'(gateOut), int'(k <= 10));
            step();
        end
        chk("retrig acc_cnt", int'(accCnt), a0 + 2);
        chk("retrig lost_cnt", int'(lostCnt), l0);
        // same without retrigger: second edge lost
        cfg(2, 5, 0, 1'b0);
        a0 = int'(accCnt); l0 = int'(lostCnt);
        edgeHit();
        run(4);
        edgeHit();
        chk("noretrig lost pulse", int'(hitLost), 1);
        for (int k = 6; k <= 9; k++) begin
            chk($sformatf("noretrig gate k=%0d", k), int'(gateOut), int'(k <= 7));
            step();
        end
        chk("noretrig acc_cnt", int'(accCnt), a0 + 1);
        chk("noretrig lost_cnt", int'(lostCnt), l0 + 1);
        // level held high through reset release is not a hit
        cfg(0, 1, 0, 1'b0);
        hitIn = 1'b1;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);
        chk("held level busy", int'(busy), 0);
        chk("held level acc_cnt", int'(accCnt), 0);
        hitIn = 1'b0;
        step();
        edgeHit();
        chk("post-release gate", int'(gateOut), 1);
        chk("post-release acc_cnt", int'(accCnt), 1);
        run(3);
        // reset mid-gate
        cfg(0, 10, 0, 1'b0);
        edgeHit();
        run(2);
        chk("mid gate high", int'(gateOut), 1);
        rst = 1'b1;
        step();
        chk("mid reset gate", int'(gateOut), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset acc_cnt", int'(accCnt), 0);
        rst = 1'b0;
        run(2);
        // counter saturation on the narrow instance
        cfg(0, 1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            edgeHit();
            step();
        end
        chk("wide acc_cnt 10", int'(accCnt), 10);
        chk("small acc_cnt saturated", int'(acc2), SMAX);
        cfg(0, 25, 0, 1'b0);
        edgeHit();
        for (int i = 0; i < 10; i++) begin
            step();
            edgeHit();
        end
        chk("wide lost_cnt 10", int'(lostCnt), 10);
        chk("small lost_cnt saturated", int'(lost2), SMAX);
        run(10);
        // random traffic with config churn every cycle
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 2) == 0) hitIn = ~hitIn;
            dlyCfg = TW'($urandom_range(0, 4));
            widCfg = TW'($urandom_range(0, 5));
            deadCfg = TW'($urandom_range(0, 3));
            retrigEn = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
